multicycle_controller: RTL

Multi-cycle main control FSM for the RISC-V datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states, and waits on a memory-ready handshake instead of assuming single-cycle memory. It drives the same datapath control signals as the single-cycle decoder, plus PC/IR write enables, a sticky trap with cause, and a retired-instruction counter. It sits between the instruction register's opcode field and the datapath muxes, register file and data memory.

---
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/multicycle_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
// Groups the opcode/memory-ready inputs and every datapath control output of
// the multi-cycle controller into one bundle.
//   master : controller side (takes opcode/memoryReady, drives the controls)
//   slave  : datapath side (drives opcode/memoryReady, consumes the controls)
// Parameter COUNT_W sets the width of the retired-instruction counter.
interface multicycle_controller_if #(
  parameter int COUNT_W = 32
);
  logic [6:0]         opcode;
  logic               memoryReady;
  logic               pcWrite;
  logic               irWrite;
  logic               branch;
  logic               regWrite;
  logic               memoryToRegister;
  logic               ALUSrc;
  logic               memoryRead;
  logic               memoryWrite;
  logic [1:0]         ALUOp;
  logic               trap;
  logic [1:0]         trapCause;
  logic [3:0]         state;
  logic [COUNT_W-1:0] retired;

  modport master (
    input  opcode, memoryReady,
    output pcWrite, irWrite, branch, regWrite, memoryToRegister, ALUSrc,
           memoryRead, memoryWrite, ALUOp, trap, trapCause, state, retired
  );

  modport slave (
    output opcode, memoryReady,
    input  pcWrite, irWrite, branch, regWrite, memoryToRegister, ALUSrc,
           memoryRead, memoryWrite, ALUOp, trap, trapCause, state, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Main control FSM for the multi-cycle RISC-V datapath. Steps each
// instruction through fetch / decode / execute / memory / write-back, waits
// on memoryReady in the memory states, traps (sticky) on illegal opcodes or
// a memory that stays not-ready too long, and counts retired instructions.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : multicycle_controller_if.master (opcode, memoryReady in; PC/IR
//           enables, datapath controls, trap/trapCause, state, retired out)
// Parameters:
//   MEM_TIMEOUT : consecutive not-ready cycles that trip the trap (0 = off)
//   COUNT_W     : retired counter width (must match the interface)
// Configuration macro:
//   CONTROLLER_ITYPE_EN : when defined, opcode 0010011 executes via EXEC_I;
//                         otherwise it is treated as illegal.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_W     = 32
) (
  input logic                    clock,
  input logic                    reset,
  multicycle_controller_if.master bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_I    = 4'd4,
    S_ADDR      = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_WB_ALU    = 4'd8,
    S_WB_MEM    = 4'd9,
    S_BRANCH    = 4'd10,
    S_TRAP      = 4'd15
  } state_t;

  typedef struct packed {
    logic       branch;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] alu_op;
    logic       trap;
  } ctrl_t;

  // Moore control decode; registered against the next state so the flops
  // always hold the decode of the current state.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:     c.mem_read = 1'b1;
      S_EXEC_R:    c.alu_op = 2'b10;
      S_EXEC_I:    begin c.alu_op = 2'b11; c.alu_src = 1'b1; end
      S_ADDR:      c.alu_src = 1'b1;
      S_MEM_READ:  begin c.mem_read = 1'b1; c.alu_src = 1'b1; end
      S_MEM_WRITE: begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
      S_WB_ALU:    c.reg_write = 1'b1;
      S_WB_MEM:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_BRANCH:    begin c.branch = 1'b1; c.alu_op = 2'b01; end
      S_TRAP:      c.trap = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  state_t             state_q, state_d;
  ctrl_t              ctrl_q;
  logic [1:0]         cause_q, cause_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [COUNT_W-1:0] retired_q, retired_d;
  logic               in_mem_state;
  logic               mem_stall;
  logic               timeout;

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                        (state_q == S_MEM_WRITE);
  assign mem_stall    = in_mem_state && !bus.memoryReady;
  // The MEM_TIMEOUT-th consecutive stall cycle trips; ready in that cycle wins.
  assign timeout      = (MEM_TIMEOUT != 0) && mem_stall &&
                        (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    wait_d    = wait_q;
    retired_d = retired_q;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.memoryReady) state_d = S_DECODE;
        else if (timeout) begin state_d = S_TRAP; cause_d = CAUSE_TIMEOUT; end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:           state_d = S_EXEC_R;
          OP_LOAD, OP_STORE:  state_d = S_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
`ifdef CONTROLLER_ITYPE_EN
          OP_ITYPE:           state_d = S_EXEC_I;
`endif
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_ADDR: state_d = (bus.opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (bus.memoryReady) state_d = S_WB_MEM;
        else if (timeout) begin state_d = S_TRAP; cause_d = CAUSE_TIMEOUT; end
      end
      S_MEM_WRITE: begin
        if (bus.memoryReady) state_d = S_FETCH;
        else if (timeout) begin state_d = S_TRAP; cause_d = CAUSE_TIMEOUT; end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH: state_d = S_FETCH;
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase

    // Any state change clears the stall count, so each memory state starts at 0.
    if (state_d != state_q) wait_d = '0;
    else if (mem_stall)     wait_d = wait_q + 1'b1;

    if ((state_d == S_FETCH) &&
        ((state_q == S_WB_ALU) || (state_q == S_WB_MEM) ||
         (state_q == S_MEM_WRITE) || (state_q == S_BRANCH)))
      retired_d = retired_q + COUNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      cause_q   <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= decode_ctrl(state_d);
      cause_q   <= cause_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // PC/IR loads fire in the same cycle the fetch completes.
  assign bus.pcWrite          = (state_q == S_FETCH) && bus.memoryReady;
  assign bus.irWrite          = (state_q == S_FETCH) && bus.memoryReady;
  assign bus.branch           = ctrl_q.branch;
  assign bus.regWrite         = ctrl_q.reg_write;
  assign bus.memoryToRegister = ctrl_q.mem_to_reg;
  assign bus.ALUSrc           = ctrl_q.alu_src;
  assign bus.memoryRead       = ctrl_q.mem_read;
  assign bus.memoryWrite      = ctrl_q.mem_write;
  assign bus.ALUOp            = ctrl_q.alu_op;
  assign bus.trap             = ctrl_q.trap;
  assign bus.trapCause        = cause_q;
  assign bus.state            = state_q;
  assign bus.retired          = retired_q;

endmodule
